// File: rtl/vote.sv
// rtl/vote.sv - four-candidate ballot counter with a single CW-bit display output
// Optional VOTE_INVALID_CNT_EN adds an invalid-press counter shown after the winner.
module vote #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          Power,
    input  logic          Close,
    input  logic          Clear,
    input  logic          Ballot,
    input  logic          Total,
    input  logic          Result,
    input  logic [3:0]    IN,
    output logic [CW-1:0] out
);

    typedef enum logic [1:0] {
        S_OPEN,
        S_ARMED,
        S_CLOSED
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef VOTE_INVALID_CNT_EN
    localparam logic [2:0] IDX_LAST = 3'd5;
`else
    localparam logic [2:0] IDX_LAST = 3'd4;
`endif

    // Button bit order: Close, Clear, Ballot, Total, Result
    localparam int B_CLOSE  = 0;
    localparam int B_CLEAR  = 1;
    localparam int B_BALLOT = 2;
    localparam int B_TOTAL  = 3;
    localparam int B_RESULT = 4;

    state_t        state, state_n;
    logic [CW-1:0] cnt   [4];
    logic [CW-1:0] cnt_n [4];
    logic [CW-1:0] total, total_n;
    logic [CW-1:0] out_n;
    logic [2:0]    idx, idx_n;
    logic [4:0]    hist;
    logic [4:0]    btn;
    logic [4:0]    rise;
    logic [3:0]    winner;
    logic [CW-1:0] best;
    logic [CW-1:0] disp;
    logic          do_result, do_ballot, do_vote, onehot;
`ifdef VOTE_INVALID_CNT_EN
    logic [CW-1:0] inv_cnt, inv_cnt_n;
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign btn  = {Result, Total, Ballot, Clear, Close};
    assign rise = btn & ~hist;

    // Strict compare keeps the lowest index on ties; all-zero counts leave no winner
    always_comb begin
        winner = '0;
        best   = '0;
        for (int i = 0; i < 4; i++) begin
            if (cnt[i] > best) begin
                best   = cnt[i];
                winner = '0;
                winner[i] = 1'b1;
            end
        end
    end

    always_comb begin
        disp = '0;
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: disp = cnt[idx[1:0]];
            3'd4:                   disp = {{(CW-4){1'b0}}, winner};
`ifdef VOTE_INVALID_CNT_EN
            3'd5:                   disp = inv_cnt;
`endif
            default:                disp = '0;
        endcase
    end

    assign onehot    = ((IN & (IN - 4'd1)) == 4'd0);
    assign do_result = rise[B_RESULT] && (state == S_CLOSED);
    assign do_ballot = rise[B_BALLOT] && (state == S_OPEN);
    assign do_vote   = (state == S_ARMED) && (IN != 4'd0);

    always_comb begin
        state_n = state;
        total_n = total;
        out_n   = out;
        idx_n   = idx;
        for (int i = 0; i < 4; i++) cnt_n[i] = cnt[i];
`ifdef VOTE_INVALID_CNT_EN
        inv_cnt_n = inv_cnt;
`endif
        if (rise[B_CLEAR]) begin
            state_n = S_OPEN;
            total_n = '0;
            out_n   = '0;
            idx_n   = '0;
            for (int i = 0; i < 4; i++) cnt_n[i] = '0;
`ifdef VOTE_INVALID_CNT_EN
            inv_cnt_n = '0;
`endif
        end else if (rise[B_CLOSE]) begin
            state_n = S_CLOSED;
            out_n   = total;
            idx_n   = '0;
        end else if (rise[B_TOTAL]) begin
            out_n = total;
        end else if (do_result) begin
            out_n = disp;
            idx_n = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else if (do_ballot) begin
            state_n = S_ARMED;
            out_n   = '0;
        end else if (do_vote) begin
            state_n = S_OPEN;
            if (onehot) begin
                total_n = sat_inc(total);
                for (int i = 0; i < 4; i++) begin
                    if (IN[i]) cnt_n[i] = sat_inc(cnt[i]);
                end
            end
`ifdef VOTE_INVALID_CNT_EN
            else begin
                inv_cnt_n = sat_inc(inv_cnt);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge Power) begin
        if (!Power) begin
            state <= S_OPEN;
            total <= '0;
            out   <= '0;
            idx   <= '0;
            hist  <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
`ifdef VOTE_INVALID_CNT_EN
            inv_cnt <= '0;
`endif
        end else begin
            state <= state_n;
            total <= total_n;
            out   <= out_n;
            idx   <= idx_n;
            hist  <= btn;
            for (int i = 0; i < 4; i++) cnt[i] <= cnt_n[i];
`ifdef VOTE_INVALID_CNT_EN
            inv_cnt <= inv_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_vote.sv
// tb/tb_vote.sv - directed self-checking bench for the vote ballot counter
module tb_vote;

    localparam int CW = 12;
    localparam logic [4:0] M_CLOSE  = 5'b00001;
    localparam logic [4:0] M_CLEAR  = 5'b00010;
    localparam logic [4:0] M_BALLOT = 5'b00100;
    localparam logic [4:0] M_TOTAL  = 5'b01000;
    localparam logic [4:0] M_RESULT = 5'b10000;

    logic          clk = 1'b0;
    logic          power;
    logic [4:0]    btn;
    logic [3:0]    in_keys;
    logic [CW-1:0] out;
    int            total_n = 0;
    int            bad_n = 0;
    logic [CW-1:0] exp_res [5];

    vote #(.CW(CW)) dut (
        .clk    (clk),
        .Power  (power),
        .Close  (btn[0]),
        .Clear  (btn[1]),
        .Ballot (btn[2]),
        .Total  (btn[3]),
        .Result (btn[4]),
        .IN     (in_keys),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a button mask for one edge; out is settled at the following negedge
    task automatic pulse(input logic [4:0] m);
        @(negedge clk);
        btn = m;
        @(negedge clk);
        btn = '0;
    endtask

    task automatic press_in(input logic [3:0] v);
        @(negedge clk);
        in_keys = v;
        @(negedge clk);
        in_keys = '0;
    endtask

    task automatic vote_for(input logic [3:0] v);
        pulse(M_BALLOT);
        press_in(v);
    endtask

    task automatic power_cycle();
        @(negedge clk);
        power = 1'b0;
        @(negedge clk);
        power = 1'b1;
    endtask

    initial begin
        power   = 1'b0;
        btn     = '0;
        in_keys = '0;
        #1;
        chk("reset_out", out, 12'h000);
        repeat (2) @(negedge clk);
        power = 1'b1;

        pulse(M_CLEAR);
        chk("clear_out", out, 12'h000);
        pulse(M_TOTAL);
        chk("total_empty", out, 12'h000);

        // Held key counts once; a later key press without Ballot adds nothing
        pulse(M_BALLOT);
        @(negedge clk);
        in_keys = 4'b0001;
        repeat (20) @(negedge clk);
        in_keys = 4'b0010;
        repeat (3) @(negedge clk);
        in_keys = 4'b0000;
        pulse(M_TOTAL);
        chk("held_key_total", out, 12'h001);

        pulse(M_BALLOT);
        chk("ballot_zeroes_out", out, 12'h000);
        press_in(4'b0101);
        press_in(4'b0001);
        pulse(M_TOTAL);
        chk("invalid_and_unarmed", out, 12'h001);

        // Fresh poll: 3x cand0, 2x cand2, one invalid
        pulse(M_CLEAR);
        for (int i = 0; i < 3; i++) vote_for(4'b0001);
        for (int i = 0; i < 2; i++) vote_for(4'b0100);
        vote_for(4'b1111);
        pulse(M_CLOSE);
        chk("close_total", out, 12'd5);
        exp_res[0] = 12'd3; exp_res[1] = 12'd0; exp_res[2] = 12'd2;
        exp_res[3] = 12'd0; exp_res[4] = 12'h001;
        for (int i = 0; i < 5; i++) begin
            pulse(M_RESULT);
            chk($sformatf("result_%0d", i), out, exp_res[i]);
        end
        pulse(M_RESULT);
`ifdef VOTE_INVALID_CNT_EN
        chk("result_after_winner", out, 12'd1);
        pulse(M_RESULT);
        chk("result_wrap", out, 12'd3);
`else
        chk("result_after_winner", out, 12'd3);
`endif

        // Voting after Close is ignored
        pulse(M_BALLOT);
        press_in(4'b0001);
        pulse(M_TOTAL);
        chk("closed_vote_ignored", out, 12'd5);

        pulse(M_CLEAR);
        chk("clear_closed", out, 12'h000);
        pulse(M_RESULT);
        chk("result_ignored_open", out, 12'h000);
        pulse(M_CLEAR | M_BALLOT);
        press_in(4'b0001);
        pulse(M_TOTAL);
        chk("clear_beats_ballot", out, 12'h000);
        vote_for(4'b1000);
        pulse(M_TOTAL);
        chk("reopen_vote_total", out, 12'd1);

        // Power loss while armed is immediate
        pulse(M_BALLOT);
        pulse(M_TOTAL);
        chk("armed_total", out, 12'd1);
        @(negedge clk);
        power = 1'b0;
        #1;
        chk("power_off_async", out, 12'h000);
        @(negedge clk);
        power = 1'b1;
        press_in(4'b0001);
        pulse(M_TOTAL);
        chk("no_vote_after_power", out, 12'h000);

        // Tie goes to the lower index
        vote_for(4'b0010);
        vote_for(4'b0100);
        pulse(M_CLOSE);
        chk("tie_close", out, 12'd2);
        exp_res[0] = 12'd0; exp_res[1] = 12'd1; exp_res[2] = 12'd1;
        exp_res[3] = 12'd0; exp_res[4] = 12'h002;
        for (int i = 0; i < 5; i++) begin
            pulse(M_RESULT);
            chk($sformatf("tie_result_%0d", i), out, exp_res[i]);
        end

        // No-vote poll has no winner
        power_cycle();
        pulse(M_CLOSE);
        for (int i = 0; i < 5; i++) pulse(M_RESULT);
        chk("no_winner", out, 12'h000);

        // Saturation at 2**CW-1
        power_cycle();
        for (int i = 0; i < 4100; i++) vote_for(4'b0001);
        pulse(M_TOTAL);
        chk("total_saturates", out, 12'hfff);
        pulse(M_CLOSE);
        pulse(M_RESULT);
        chk("cnt_saturates", out, 12'hfff);
        pulse(M_RESULT);
        chk("cnt1_after_sat", out, 12'h000);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
